pc_counter_n: RTL and testbench

Parametrised program counter for the Hack CPU datapath. It generalises the fixed 16-bit +1 incrementer into a registered counter with:
- configurable width and step
- increment, decrement and load
- wrap or saturate overflow mode
- a small hardware return-address stack for call/return.

It sits between the ALU/jump logic and the ROM address port.

---
 rtl/pc_counter_n_pkg.sv | 19 +
 rtl/pc_counter_n_return_stack.sv | 47 ++++
 rtl/pc_counter_n.sv | 119 +++++++++++
 tb/tb_pc_counter_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_counter_n_pkg.sv
// Shared definitions for the parametrised Hack program counter:
// command encoding after priority resolution and return-stack pointer sizing.
package pc_counter_n_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_DEC  = 3'd2,
        OP_LOAD = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_t;

    // One extra bit so that "full" (ptr == DEPTH) is distinguishable from "empty".
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_counter_n_return_stack.sv
// DEPTH x WIDTH LIFO holding return addresses; reset clears only the pointer,
// the storage array keeps whatever it held.
module return_stack
    import pc_counter_n_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    ptr;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty   = (ptr == '0);
    assign full    = (ptr == PW'(DEPTH));
    assign top_idx = ptr[AW-1:0] - AW'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + PW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_counter_n.sv
// Registered program counter with step inc/dec, load, wrap/saturate overflow
// handling and a hardware return-address stack for call/return.
module pc_counter_n
    import pc_counter_n_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               STEP      = 1,
    parameter int               DEPTH     = 4,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    op_t              op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] out_n;
    logic [WIDTH-1:0] stk_top;
    logic             wrap_n;
    logic             err_n;
    logic             stk_push;
    logic             stk_pop;

    always_comb begin
        op = OP_HOLD;
        if (pop) begin
            op = OP_RET;
        end else if (load) begin
            op = push ? OP_CALL : OP_LOAD;
        end else if (dec) begin
            op = OP_DEC;
        end else if (inc) begin
            op = OP_INC;
        end
    end

    // Carry/borrow out of the extra top bit is exactly the overflow condition.
    assign sum  = {1'b0, out} + STEP_X;
    assign diff = {1'b0, out} - STEP_X;

    always_comb begin
        out_n    = out;
        wrap_n   = 1'b0;
        err_n    = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        unique case (op)
            OP_RET: begin
                if (stack_empty) begin
                    err_n = 1'b1;
                end else begin
                    out_n   = stk_top;
                    stk_pop = 1'b1;
                end
            end
            OP_CALL: begin
                out_n = in;
                if (stack_full) begin
                    err_n = 1'b1;
                end else begin
                    stk_push = 1'b1;
                end
            end
            OP_LOAD: out_n = in;
            OP_DEC: begin
                wrap_n = diff[WIDTH];
                out_n  = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            end
            OP_INC: begin
                wrap_n = sum[WIDTH];
                out_n  = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end
            default: out_n = out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= RESET_VAL;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            out  <= out_n;
            wrap <= wrap_n;
            err  <= err_n;
        end
    end

    // The saved return address always wraps, independent of SATURATE.
    return_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_stack (
        .clk  (clk),
        .reset(reset),
        .push (stk_push),
        .pop  (stk_pop),
        .din  (sum[WIDTH-1:0]),
        .top  (stk_top),
        .full (stack_full),
        .empty(stack_empty)
    );

endmodule

// File: tb/tb_pc_counter_n.sv
// Bench for pc_counter_n: four configurations driven in lockstep, directed
// vectors on the 16-bit instances and a queue-based reference model for all.
module tb_pc_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load, inc, dec, push, pop;
    logic [15:0] in;
    logic [15:0] out_a, out_b;
    logic [7:0]  out_c, out_d;
    logic [3:0]  se, sf, wr, er;

    pc_counter_n #(.WIDTH(16), .STEP(1), .DEPTH(4), .SATURATE(1'b0), .RESET_VAL(16'h0000)) u_a (
        .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc), .dec(dec), .push(push), .pop(pop),
        .out(out_a), .stack_empty(se[0]), .stack_full(sf[0]), .wrap(wr[0]), .err(er[0]));
    pc_counter_n #(.WIDTH(16), .STEP(1), .DEPTH(4), .SATURATE(1'b1), .RESET_VAL(16'h0000)) u_b (
        .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc), .dec(dec), .push(push), .pop(pop),
        .out(out_b), .stack_empty(se[1]), .stack_full(sf[1]), .wrap(wr[1]), .err(er[1]));
    pc_counter_n #(.WIDTH(8), .STEP(3), .DEPTH(4), .SATURATE(1'b0), .RESET_VAL(8'h07)) u_c (
        .clk(clk), .reset(reset), .in(in[7:0]), .load(load), .inc(inc), .dec(dec), .push(push), .pop(pop),
        .out(out_c), .stack_empty(se[2]), .stack_full(sf[2]), .wrap(wr[2]), .err(er[2]));
    pc_counter_n #(.WIDTH(8), .STEP(3), .DEPTH(4), .SATURATE(1'b1), .RESET_VAL(8'h00)) u_d (
        .clk(clk), .reset(reset), .in(in[7:0]), .load(load), .inc(inc), .dec(dec), .push(push), .pop(pop),
        .out(out_d), .stack_empty(se[3]), .stack_full(sf[3]), .wrap(wr[3]), .err(er[3]));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one entry per instance, return stack as a queue.
    int mw[4]  = '{16, 16, 8, 8};
    int ms[4]  = '{1, 1, 3, 3};
    bit msat[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int mrv[4] = '{0, 0, 7, 0};
    int mout[4];
    int mq[4][$];
    bit mwrap[4];
    bit merr[4];
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_out(input int i);
        case (i)
            0:       return {16'h0, out_a};
            1:       return {16'h0, out_b};
            2:       return {24'h0, out_c};
            default: return {24'h0, out_d};
        endcase
    endfunction

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            int mx;
            mx = (1 << mw[i]) - 1;
            mwrap[i] = 1'b0;
            merr[i]  = 1'b0;
            if (reset) begin
                mout[i] = mrv[i];
                mq[i].delete();
            end else if (pop) begin
                if (mq[i].size() > 0) mout[i] = mq[i].pop_back();
                else merr[i] = 1'b1;
            end else if (load) begin
                if (push) begin
                    if (mq[i].size() < 4) mq[i].push_back((mout[i] + ms[i]) % (mx + 1));
                    else merr[i] = 1'b1;
                end
                mout[i] = int'(in) & mx;
            end else if (dec) begin
                if (mout[i] < ms[i]) begin
                    mwrap[i] = 1'b1;
                    mout[i]  = msat[i] ? 0 : mout[i] - ms[i] + mx + 1;
                end else begin
                    mout[i] = mout[i] - ms[i];
                end
            end else if (inc) begin
                if (mout[i] + ms[i] > mx) begin
                    mwrap[i] = 1'b1;
                    mout[i]  = msat[i] ? mx : mout[i] + ms[i] - mx - 1;
                end else begin
                    mout[i] = mout[i] + ms[i];
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m%0d_out", i),   dut_out(i), mout[i]);
            chk($sformatf("m%0d_empty", i), se[i], mq[i].size() == 0);
            chk($sformatf("m%0d_full", i),  sf[i], mq[i].size() == 4);
            chk($sformatf("m%0d_wrap", i),  wr[i], mwrap[i]);
            chk($sformatf("m%0d_err", i),   er[i], merr[i]);
        end
    endtask

    task automatic step(input bit r, input bit l, input bit ic, input bit dc,
                        input bit ps, input bit pp, input logic [15:0] v);
        reset = r; load = l; inc = ic; dec = dc; push = ps; pop = pp; in = v;
        @(posedge clk);
        model_step();
        if (r) model_on = 1'b1;
        #1;
        if (model_on) check_model();
    endtask

    typedef struct {
        bit          r, l, ic, dc, ps, pp;
        logic [15:0] v;
        logic [15:0] eo;
        bit          ee, ef, ew, eer;
    } vec_t;

    vec_t tbl[15];

    initial begin
        reset = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0; push = 1'b0; pop = 1'b0; in = '0;

        //            r  l  ic dc ps pp  in        out      e  f  w  err
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, 0, 16'h0000, 16'h0003, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 16'h0010, 16'h0010, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 1, 0, 16'h0200, 16'h0200, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 1, 16'h0000, 16'h0011, 1, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 16'h0005, 16'h0005, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 0, 0, 16'h0000, 16'h0004, 1, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 16'h0000, 16'h0004, 1, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 1, 0, 16'h0000, 16'h0004, 1, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 1, 0, 0, 16'h0000, 16'h0003, 1, 0, 0, 0};

        for (int k = 0; k < 15; k++) begin
            step(tbl[k].r, tbl[k].l, tbl[k].ic, tbl[k].dc, tbl[k].ps, tbl[k].pp, tbl[k].v);
            chk($sformatf("v%0d_out", k),   out_a, tbl[k].eo);
            chk($sformatf("v%0d_empty", k), se[0], tbl[k].ee);
            chk($sformatf("v%0d_full", k),  sf[0], tbl[k].ef);
            chk($sformatf("v%0d_wrap", k),  wr[0], tbl[k].ew);
            chk($sformatf("v%0d_err", k),   er[0], tbl[k].eer);
        end

        // Saturating overflow at both ends, compared to wrapping.
        step(0, 1, 0, 0, 0, 0, 16'hFFFF);
        step(0, 0, 1, 0, 0, 0, 16'h0000);
        chk("sat_inc_out", out_b, 16'hFFFF);
        chk("sat_inc_wrap", wr[1], 1'b1);
        step(0, 1, 0, 0, 0, 0, 16'h0000);
        step(0, 0, 0, 1, 0, 0, 16'h0000);
        chk("sat_dec_out", out_b, 16'h0000);
        chk("sat_dec_wrap", wr[1], 1'b1);
        chk("wrp_dec_out", out_a, 16'hFFFF);
        chk("wrp_dec_wrap", wr[0], 1'b1);

        // Five calls into a 4-deep stack, then drain past empty.
        step(1, 0, 0, 0, 0, 0, 16'h0000);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 1, 0, 16'((k + 1) * 16'h0100));
            if (k == 3) chk("call4_full", sf[0], 1'b1);
            if (k == 3) chk("call4_err", er[0], 1'b0);
        end
        chk("call5_err", er[0], 1'b1);
        chk("call5_full", sf[0], 1'b1);
        chk("call5_out", out_a, 16'h0500);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 1, 16'h0000);
            chk($sformatf("ret%0d_out", k), out_a, 16'((3 - k) * 16'h0100 + 1));
            chk($sformatf("ret%0d_err", k), er[0], 1'b0);
        end
        step(0, 0, 0, 0, 0, 1, 16'h0000);
        chk("ret5_err", er[0], 1'b1);
        chk("ret5_out", out_a, 16'h0001);
        chk("ret5_empty", se[0], 1'b1);

        // Pop wins over load and inc in the same cycle.
        step(0, 1, 0, 0, 0, 0, 16'h0041);
        step(0, 1, 0, 0, 1, 0, 16'h0900);
        step(0, 1, 1, 0, 0, 1, 16'h1234);
        chk("pop_prio_out", out_a, 16'h0042);

        // Reset discards pending return entries.
        step(0, 1, 0, 0, 1, 0, 16'h0010);
        step(0, 1, 0, 0, 1, 0, 16'h0020);
        step(1, 0, 0, 0, 0, 0, 16'h0000);
        chk("rst_out", out_a, 16'h0000);
        chk("rst_empty", se[0], 1'b1);
        step(0, 0, 0, 0, 0, 1, 16'h0000);
        chk("rst_pop_err", er[0], 1'b1);

        // Randomised commands checked against the model on every instance.
        step(1, 0, 0, 0, 0, 0, 16'h0000);
        for (int k = 0; k < 1000; k++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 0,  $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 0,  $urandom_range(0, 4) == 0,
                 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
